// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage. Owns the program counter, issues
// synchronous ROM reads and presents each fetched word to the decoder over a
// valid/ready handshake, with jump redirect and halt taken on the handshake.
module fetch_unit #(
    parameter int unsigned          ADDR_W   = 8,
    parameter int unsigned          INSTR_W  = 24,
    parameter logic [ADDR_W-1:0]    RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    output logic               rom_en,
    output logic [ADDR_W-1:0]  rom_addr,
    input  logic [INSTR_W-1:0] rom_data,
    output logic [INSTR_W-1:0] instr,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [ADDR_W-1:0]  pc,
    input  logic               jump_en,
    input  logic [ADDR_W-1:0]  jump_addr,
    input  logic               halt,
    output logic               halted
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ISSUE  = 3'd1,
        WAIT   = 3'd2,
        VALID  = 3'd3,
        HALTED = 3'd4
    } state_e;

    state_e              state_q;
    logic [ADDR_W-1:0]   fetch_addr_q;
    logic [ADDR_W-1:0]   pc_q;
    logic [INSTR_W-1:0]  instr_q;
    logic                rom_en_q;
    logic                instr_valid_q;
    logic                halted_q;
    logic                handshake;
    logic [ADDR_W-1:0]   fetch_addr_d;

    // Handshake and the address to fetch after it (jump wins over sequential).
    assign handshake    = instr_valid_q & instr_ready;
    assign fetch_addr_d = jump_en ? jump_addr : pc_q + ADDR_W'(1);

    // Fetch state machine; the strobes are registered alongside the state so
    // each is a clean decode of the state it belongs to.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            fetch_addr_q  <= RESET_PC;
            pc_q          <= RESET_PC;
            instr_q       <= '0;
            rom_en_q      <= 1'b0;
            instr_valid_q <= 1'b0;
            halted_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_q  <= ISSUE;
                    rom_en_q <= 1'b1;
                end
                ISSUE: begin
                    state_q  <= WAIT;
                    rom_en_q <= 1'b0;
                end
                WAIT: begin
                    state_q       <= VALID;
                    instr_q       <= rom_data;
                    pc_q          <= fetch_addr_q;
                    instr_valid_q <= 1'b1;
                end
                VALID: begin
                    if (handshake) begin
                        fetch_addr_q  <= fetch_addr_d;
                        instr_valid_q <= 1'b0;
                        if (halt) begin
                            state_q  <= HALTED;
                            halted_q <= 1'b1;
                        end else begin
                            state_q  <= ISSUE;
                            rom_en_q <= 1'b1;
                        end
                    end
                end
                HALTED: begin
                    state_q <= HALTED;
                end
                default: begin
                    state_q       <= IDLE;
                    rom_en_q      <= 1'b0;
                    instr_valid_q <= 1'b0;
                    halted_q      <= 1'b0;
                end
            endcase
        end
    end

    assign rom_en      = rom_en_q;
    assign rom_addr    = fetch_addr_q;
    assign instr       = instr_q;
    assign instr_valid = instr_valid_q;
    assign pc          = pc_q;
    assign halted      = halted_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit with a behavioural synchronous ROM.
module tb_fetch_unit;

    localparam int unsigned ADDR_W  = 8;
    localparam int unsigned INSTR_W = 24;

    logic               clk;
    logic               rst;
    logic               rom_en;
    logic [ADDR_W-1:0]  rom_addr;
    logic [INSTR_W-1:0] rom_data;
    logic [INSTR_W-1:0] instr;
    logic               instr_valid;
    logic               instr_ready;
    logic [ADDR_W-1:0]  pc;
    logic               jump_en;
    logic [ADDR_W-1:0]  jump_addr;
    logic               halt;
    logic               halted;

    logic [INSTR_W-1:0] mem [256];

    int errors = 0;
    int checks = 0;

    fetch_unit #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .RESET_PC(8'h00)) dut (
        .clk         (clk),
        .rst         (rst),
        .rom_en      (rom_en),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .pc          (pc),
        .jump_en     (jump_en),
        .jump_addr   (jump_addr),
        .halt        (halt),
        .halted      (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous ROM: data appears the cycle after the strobe.
    always @(posedge clk) begin
        if (rom_en) rom_data <= mem[rom_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk_valid(input string tag, input logic [23:0] exp_instr, input logic [7:0] exp_pc);
        chk({tag, "_valid"}, 32'(instr_valid), 32'd1);
        chk({tag, "_instr"}, 32'(instr), 32'(exp_instr));
        chk({tag, "_pc"}, 32'(pc), 32'(exp_pc));
    endtask

    task automatic chk_issue(input string tag, input logic [7:0] exp_addr);
        chk({tag, "_rom_en"}, 32'(rom_en), 32'd1);
        chk({tag, "_rom_addr"}, 32'(rom_addr), 32'(exp_addr));
        chk({tag, "_valid"}, 32'(instr_valid), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = {8'hA5, 8'(i), 8'(~i)};
        mem[0]     = 24'h111111;
        mem[1]     = 24'h222222;
        mem[2]     = 24'h333333;
        mem[3]     = 24'hABCDEF;
        mem[8'h40] = 24'h404040;
        mem[8'hFF] = 24'hFFEEDD;

        rst         = 1'b0;
        instr_ready = 1'b1;
        jump_en     = 1'b0;
        jump_addr   = '0;
        halt        = 1'b0;

        // Reset state.
        #1;
        chk("rst_rom_en", 32'(rom_en), 32'd0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_instr", 32'(instr), 32'd0);
        chk("rst_pc", 32'(pc), 32'd0);
        step();
        step();
        chk("rst_hold_rom_en", 32'(rom_en), 32'd0);
        rst = 1'b1;
        #1;
        chk("e0_rom_en", 32'(rom_en), 32'd0);

        // Sequential fetch: E1 issue, E2 wait, E3 valid.
        step(); chk_issue("e1", 8'h00);
        step();
        chk("e2_rom_en", 32'(rom_en), 32'd0);
        chk("e2_valid", 32'(instr_valid), 32'd0);
        step(); chk_valid("e3", 24'h111111, 8'h00);
        step(); chk_issue("e4", 8'h01);
        step();
        step(); chk_valid("e6", 24'h222222, 8'h01);

        // Backpressure; jump/halt driven during stall must be ignored.
        instr_ready = 1'b0;
        jump_en     = 1'b1;
        jump_addr   = 8'h80;
        halt        = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk_valid("stall", 24'h222222, 8'h01);
            chk("stall_rom_en", 32'(rom_en), 32'd0);
            chk("stall_halted", 32'(halted), 32'd0);
        end

        // Jump taken on the handshake of pc=0x01.
        instr_ready = 1'b1;
        halt        = 1'b0;
        jump_addr   = 8'h40;
        step(); chk_issue("jmp", 8'h40);
        jump_en = 1'b0;
        step();
        step(); chk_valid("jmp_tgt", 24'h404040, 8'h40);

        // Jump to the top of the address space, then sequential wrap.
        jump_en   = 1'b1;
        jump_addr = 8'hFF;
        step(); chk_issue("jmp_ff", 8'hFF);
        jump_en = 1'b0;
        step();
        step(); chk_valid("pc_ff", 24'hFFEEDD, 8'hFF);
        step(); chk_issue("wrap", 8'h00);
        step();
        step(); chk_valid("wrap_tgt", 24'h111111, 8'h00);

        // Halt together with jump on the same handshake.
        halt      = 1'b1;
        jump_en   = 1'b1;
        jump_addr = 8'h55;
        step();
        halt    = 1'b0;
        jump_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("halt_halted", 32'(halted), 32'd1);
            chk("halt_rom_en", 32'(rom_en), 32'd0);
            chk("halt_valid", 32'(instr_valid), 32'd0);
            instr_ready = 1'(i % 2);
            step();
        end
        instr_ready = 1'b1;

        // Reset releases HALTED and restarts at RESET_PC.
        rst = 1'b0;
        #1;
        chk("rst2_halted", 32'(halted), 32'd0);
        chk("rst2_pc", 32'(pc), 32'd0);
        chk("rst2_instr", 32'(instr), 32'd0);
        step();
        rst = 1'b1;
        step(); chk_issue("r2_e1", 8'h00);
        step();
        step(); chk_valid("r2_e3", 24'h111111, 8'h00);
        step();
        step();
        step(); chk_valid("r2_e6", 24'h222222, 8'h01);
        step();
        step();
        step(); chk_valid("r2_e9", 24'h333333, 8'h02);
        step(); chk_issue("r2_e10", 8'h03);
        step();
        chk("wait_rom_data", 32'(rom_data), 32'hABCDEF);

        // Reset while in WAIT: the returning word must never be captured.
        rst = 1'b0;
        #1;
        chk("midrst_instr", 32'(instr), 32'd0);
        chk("midrst_valid", 32'(instr_valid), 32'd0);
        chk("midrst_rom_en", 32'(rom_en), 32'd0);
        step();
        chk("midrst_hold_instr", 32'(instr), 32'd0);
        chk("midrst_hold_valid", 32'(instr_valid), 32'd0);
        rst = 1'b1;
        step(); chk_issue("r3_e1", 8'h00);
        step();
        step(); chk_valid("r3_e3", 24'h111111, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
